mem_req_arbiter: RTL

Two-port request arbiter that shares one downstream memory request/response port between two requesters, such as instruction fetch (port 0) and load/store (port 1). Requests use valid/ready handshakes. Grant selection is combinational (zero-latency pass-through) and is locked while the downstream port stalls. A 2-entry ordered ID queue records which requester owns each outstanding request, so that in-order responses are routed back to their owner. The block sits between the core's fetch/LSU front ends and the single bus/cache port.

---
 rtl/mem_req_arbiter_pkg.sv | 26 ++
 rtl/mem_req_arbiter_if.sv | 47 ++++
 rtl/mem_req_arbiter_id_queue.sv | 76 +++++++
 rtl/mem_req_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the two-port memory request arbiter and its ordered
// ID queue.
//   ARB_NPORTS  number of upstream requesters (port 0 = fetch, port 1 = LSU)
//   ARB_QDEPTH  number of outstanding downstream requests tracked
//   ARB_CNT_W   width of the outstanding-request count (0..ARB_QDEPTH)
//   arb_id_t    owner ID recorded per outstanding request
//   arb_cnt_t   outstanding-request count
//   arb_lock_e  grant lock state (idle / held while downstream stalls)
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int ARB_NPORTS = 2;
  localparam int ARB_QDEPTH = 2;
  localparam int ARB_CNT_W  = $clog2(ARB_QDEPTH + 1);

  typedef logic                 arb_id_t;
  typedef logic [ARB_CNT_W-1:0] arb_cnt_t;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } arb_lock_e;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter_if
// One memory request/response channel: valid/ready request with payload and a
// response path without backpressure.
//   req_addr/req_wdata/req_wen  request payload (AW / DW / 1)
//   req_valid/req_ready         request handshake
//   resp_rdata/resp_valid       response data and strobe
// Modports:
//   master  issues requests, consumes responses (a requester, or the arbiter
//           facing the downstream memory)
//   slave   accepts requests, returns responses (the arbiter facing a
//           requester, or the memory)
// -----------------------------------------------------------------------------
interface mem_req_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);

  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_wen;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_valid;

  modport master (
    output req_addr,
    output req_wdata,
    output req_wen,
    output req_valid,
    input  req_ready,
    input  resp_rdata,
    input  resp_valid
  );

  modport slave (
    input  req_addr,
    input  req_wdata,
    input  req_wen,
    input  req_valid,
    output req_ready,
    output resp_rdata,
    output resp_valid
  );

endinterface

// File: rtl/mem_req_arbiter_id_queue.sv
// -----------------------------------------------------------------------------
// arb_id_queue
// Ordered queue of owner IDs, ARB_QDEPTH entries deep, implemented as a
// shift-down register file: entry 0 is always the head.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, din    append din at the tail (ignored when full)
//   pop          drop the head (ignored when empty)
//   dout         current head entry
//   empty, full  occupancy flags
//   count        number of valid entries
// Push and pop in the same cycle keep the count and preserve order.
// -----------------------------------------------------------------------------
module arb_id_queue
  import arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  arb_id_t  din,
  output arb_id_t  dout,
  output logic     empty,
  output logic     full,
  output arb_cnt_t count
);

  logic [ARB_QDEPTH-1:0] entry_reg;
  logic [ARB_QDEPTH-1:0] entry_next;
  arb_cnt_t              count_reg;
  arb_cnt_t              count_next;
  arb_cnt_t              wr_idx;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == arb_cnt_t'(ARB_QDEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // The tail slot after this cycle's pop: a simultaneous pop shifts the
  // survivors down first, so the new entry lands one slot lower.
  assign wr_idx = count_reg - arb_cnt_t'(pop_ok);

  genvar gi;
  generate
    for (gi = 0; gi < ARB_QDEPTH; gi++) begin : g_entry
      arb_id_t shift_in;
      if (gi == ARB_QDEPTH - 1) begin : g_last
        assign shift_in = 1'b0;
      end else begin : g_mid
        assign shift_in = entry_reg[gi+1];
      end

      assign entry_next[gi] = (push_ok && (wr_idx == arb_cnt_t'(gi))) ? din      :
                              pop_ok                                  ? shift_in :
                                                                        entry_reg[gi];
    end
  endgenerate

  assign count_next = count_reg + arb_cnt_t'(push_ok) - arb_cnt_t'(pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_reg <= '0;
      count_reg <= '0;
    end else begin
      entry_reg <= entry_next;
      count_reg <= count_next;
    end
  end

  assign dout  = entry_reg[0];
  assign count = count_reg;

endmodule

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
// Shares one downstream memory request/response port between two requesters
// (port 0 = instruction fetch, port 1 = load/store). Grant selection is
// combinational and is held on the stalled requester while the downstream
// port refuses a request. An ordered ID queue remembers the owner of each
// outstanding request so in-order responses are routed back to it.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   s0, s1      requester channels (slave modport of mem_req_arbiter_if)
//   m           downstream memory channel (master modport)
//   err         sticky: a response arrived with nothing outstanding
// Parameters:
//   AW, DW      address / data width; must match the interface instances
// Build option:
//   ARB_ROUND_ROBIN_EN  defined: ties alternate (fair round-robin).
//                       undefined: ties always go to port 0.
// -----------------------------------------------------------------------------
module mem_req_arbiter
  import arb_pkg::*;
#(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mem_req_arbiter_if.slave         s0,
  mem_req_arbiter_if.slave         s1,
  mem_req_arbiter_if.master        m,
  output logic                     err
);

  logic [ARB_NPORTS-1:0] req_valid;
  logic [ARB_NPORTS-1:0] req_ready;
  logic [ARB_NPORTS-1:0] resp_valid;

  arb_id_t   sel;
  arb_id_t   tie_sel;
  arb_id_t   head_id;
  arb_id_t   lock_id_reg;
  arb_lock_e state_reg;
  arb_lock_e state_next;
  logic      lock_active;

  logic      q_empty;
  logic      q_full;
  arb_cnt_t  q_count;
  logic      below_full;
  logic      handshake;
  logic      stall;
  logic      push;
  logic      pop;
  logic      err_reg;

  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;
  logic          wen_mux;

  assign req_valid = {s1.req_valid, s0.req_valid};

  // Uses the registered count only: a pop in the same cycle does not open a
  // slot until the next cycle, keeping m_req_valid off the response path.
  assign below_full = (q_count < arb_cnt_t'(ARB_QDEPTH));

  // ---------------------------------------------------------------------------
  // Tie resolution
  // ---------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  arb_id_t rr_last_reg;

  // Reset to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_reg <= 1'b1;
    end else if (handshake) begin
      rr_last_reg <= sel;
    end
  end

  assign tie_sel = ~rr_last_reg;
`else
  assign tie_sel = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  always_comb begin
    sel = tie_sel;
    if (lock_active) begin
      sel = lock_id_reg;
    end else if (req_valid == 2'b01) begin
      sel = 1'b0;
    end else if (req_valid == 2'b10) begin
      sel = 1'b1;
    end
  end

  assign addr_mux  = sel ? s1.req_addr  : s0.req_addr;
  assign wdata_mux = sel ? s1.req_wdata : s0.req_wdata;
  assign wen_mux   = sel ? s1.req_wen   : s0.req_wen;

  assign m.req_addr  = addr_mux;
  assign m.req_wdata = wdata_mux;
  assign m.req_wen   = wen_mux;
  assign m.req_valid = req_valid[sel] && below_full;

  assign handshake = m.req_valid && m.req_ready;
  assign stall     = m.req_valid && !m.req_ready;

  // ---------------------------------------------------------------------------
  // Per-port ready and response steering
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < ARB_NPORTS; gi++) begin : g_port
      assign req_ready[gi]  = (sel == arb_id_t'(gi)) && m.req_ready &&
                              below_full && req_valid[gi];
      assign resp_valid[gi] = m.resp_valid && !q_empty &&
                              (head_id == arb_id_t'(gi));
    end
  endgenerate

  assign s0.req_ready  = req_ready[0];
  assign s1.req_ready  = req_ready[1];
  assign s0.resp_valid = resp_valid[0];
  assign s1.resp_valid = resp_valid[1];
  assign s0.resp_rdata = m.resp_rdata;
  assign s1.resp_rdata = m.resp_rdata;

  // ---------------------------------------------------------------------------
  // Grant lock FSM: hold the grant on a requester the downstream has stalled
  // so its payload cannot be swapped out from under the memory port.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LOCK_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (handshake) begin
      state_next = LOCK_IDLE;
    end else if (stall) begin
      state_next = LOCK_HELD;
    end
  end

  always_comb begin
    lock_active = (state_reg == LOCK_HELD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_id_reg <= 1'b0;
    end else if (stall) begin
      lock_id_reg <= sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding request owners
  // ---------------------------------------------------------------------------
  assign push = handshake && !q_full;
  assign pop  = m.resp_valid && !q_empty;

  arb_id_queue u_id_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (sel),
    .dout  (head_id),
    .empty (q_empty),
    .full  (q_full),
    .count (q_count)
  );

  // Sticky until reset: a response with no recorded owner is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (m.resp_valid && q_empty) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;

endmodule
